wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Circular trace buffer on the CPU clock domain that records architectural write events from the pipelined MIPS_R2000 core: GPR writebacks and data-memory stores. It sits between the core's WB/MEM stages and the board display path. The display mux steps through recorded events with a pop pulse instead of sampling live `cpuData`, so every write stays visible when the CPU runs fast.

## Interface
- `DEPTH`, 16: entry count; power of two, minimum 4.
- `AW`, 4: log2(DEPTH).
- `CLK_CPU` in 1: CPU clock.
- `RST_CPU` in 1: reset, asynchronous, active-high.
- `RegWrite` in 1: GPR write this cycle (WB stage).
- `WriteRegister` in 5: GPR index.
- `WriteData` in 32: GPR write value.
- `WbPC` in 32: PC of the WB-stage instruction.
- `DMemW` in 1: data-memory store this cycle (MEM stage).
- `DataAddr` in 32: store byte address.
- `DataIn` in 32: store value.
- `MemPC` in 32: PC of the MEM-stage instruction.
- `Freeze` in 1: when high, no capture (driven by a switch).
- `Clear` in 1: synchronous flush.
- `Pop` in 1: single-cycle pulse that discards the oldest entry.
- `Valid` out 1: buffer non-empty.
- `EntryKind` out 2: 01 = GPR write, 10 = store, 00 when empty.
- `EntryAddr` out 16: register index (zero-extended) or DataAddr[15:0].
- `EntryData` out 32: written value.
- `EntryPC` out 32: PC of the recorded instruction.
- `Count` out AW+1: occupied entries, 0..DEPTH.
- `Overflow` out 1: sticky flag; at least one entry was lost.

## Operation
- Storage: DEPTH entries of {kind, addr, data, pc}; write pointer `wp`, read pointer `rp`, both AW bits, wrapping modulo DEPTH.
- Capture pushes `p = RegWrite + DMemW` entries, but only when Freeze=0 and Clear=0.
- If both events occur in one cycle, the GPR event is written at `wp` and the store at `wp+1`, because the WB instruction is older. `wp` advances by 2.
- A GPR write to register 0 is still recorded.
- Pop is honoured only when Count>0 before the edge. Pop on empty is ignored.
- Next count is `n = Count - pop_eff + p`.
- If n > DEPTH, the oldest `n-DEPTH` entries are overwritten. `rp` advances by `pop_eff + (n-DEPTH)`, Count becomes DEPTH, and Overflow is set.
- Clear: `wp`, `rp` and Count go to 0 and Overflow goes to 0. Same-cycle Pop and capture are ignored.
- Freeze=1 drops events silently. Pop and Clear still act.
- Read side: Entry outputs show the entry at `rp`, read combinationally from the registered array. All Entry outputs are forced to 0 while Valid=0.

## Timing
- Reset (async, immediate): Valid=0, Count=0, Overflow=0, EntryKind=0, EntryAddr=0, EntryData=0, EntryPC=0, wp=rp=0. Array contents are don't-care.
- Latency: an event sampled at edge k is visible on Entry outputs after edge k if the buffer was empty. Count updates at the same edge.
- Pop at edge k: the next entry is presented after edge k, with no bubble.
- Pop together with a push on a full buffer gives net Count = DEPTH - 1 + p, capped at DEPTH. Overflow is set only when the cap is hit.
- Reset asserted mid-operation discards all entries at once. Capture resumes on the first edge after RST_CPU deasserts.
- Priority per edge: RST_CPU, then Clear, then pop/push arithmetic.

## Configuration
- `TRACE_PC_EN` defined: the pc field is stored and EntryPC shows the recorded WbPC or MemPC.
- `TRACE_PC_EN` undefined: no PC storage is built and EntryPC is tied to 0. The WbPC and MemPC ports remain but are unused.

## Test plan
- Reset, then RegWrite=1, WriteRegister=8, WriteData=0x0000_0005 for one cycle -> Valid=1, Kind=01, Addr=0x0008, Data=5, Count=1.
- RegWrite (r9, 0x11) and DMemW (addr 0x0004, 0x22) in the same cycle -> Count=2. First entry is the r9 GPR write; after one Pop, the store to 0x0004 with 0x22; after a second Pop, Valid=0.
- Push DEPTH+3 sequential GPR writes with values 1..19 -> Count=16, Overflow=1, oldest shown value=4.
- Full buffer, then Pop and one push in the same cycle -> Count stays 16, Overflow unchanged, head advances by one.
- Freeze=1 with 5 writes -> Count unchanged. Then Clear -> Count=0, Overflow=0. Pop on empty -> no change.
- Assert RST_CPU mid-stream with Count=7 -> all outputs 0 immediately. With `TRACE_PC_EN`, a write with WbPC=0x0000_3008 gives EntryPC=0x3008; without it, EntryPC=0.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: circular trace buffer for MIPS_R2000 architectural writes.
// It records GPR writebacks (WB stage) and data-memory stores (MEM stage) in
// program order. The display path reads the oldest entry and pops it.
// The oldest entries are overwritten when the buffer is full, and the sticky
// Overflow flag records that this happened.
// Optional feature: define TRACE_PC_EN to store the PC of each recorded
// instruction and show it on EntryPC. Without it, EntryPC is tied to 0.
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK_CPU,
    input  logic          RST_CPU,
    input  logic          RegWrite,
    input  logic [4:0]    WriteRegister,
    input  logic [31:0]   WriteData,
    input  logic [31:0]   WbPC,
    input  logic          DMemW,
    input  logic [31:0]   DataAddr,
    input  logic [31:0]   DataIn,
    input  logic [31:0]   MemPC,
    input  logic          Freeze,
    input  logic          Clear,
    input  logic          Pop,
    output logic          Valid,
    output logic [1:0]    EntryKind,
    output logic [15:0]   EntryAddr,
    output logic [31:0]   EntryData,
    output logic [31:0]   EntryPC,
    output logic [AW:0]   Count,
    output logic          Overflow
);

    localparam logic [1:0]    KIND_GPR   = 2'b01;
    localparam logic [1:0]    KIND_STORE = 2'b10;
    localparam logic [AW+1:0] DEPTH_W    = (AW+2)'(DEPTH);
    localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);

    // Entry storage. There is no reset because contents are meaningful only
    // between rp and wp.
    logic [1:0]  kind_mem [DEPTH];
    logic [15:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
`ifdef TRACE_PC_EN
    logic [31:0] pc_mem   [DEPTH];
`endif

    logic [AW-1:0] wp_reg, wp_next;
    logic [AW-1:0] rp_reg, rp_next;
    logic [AW:0]   count_reg, count_next;
    logic          overflow_reg, overflow_next;

    logic          capture;
    logic          pop_eff;
    logic [1:0]    push_cnt;
    logic [AW+1:0] n_sum;
    logic [AW+1:0] excess;
    logic [AW-1:0] store_idx;
    logic          unused_ok;

    // Next-state arithmetic. Clear wins over pop and capture. When the buffer
    // would exceed DEPTH, the read pointer skips the overwritten entries.
    always_comb begin
        capture   = !Freeze && !Clear;
        pop_eff   = Pop && (count_reg != '0) && !Clear;
        push_cnt  = capture ? ({1'b0, RegWrite} + {1'b0, DMemW}) : 2'd0;
        // The WB instruction is older, so its GPR event goes at wp.
        // The store goes in the slot after it.
        store_idx = wp_reg + {{(AW-1){1'b0}}, RegWrite};
        n_sum     = {1'b0, count_reg}
                  - {{(AW+1){1'b0}}, pop_eff}
                  + {{AW{1'b0}}, push_cnt};
        excess        = '0;
        wp_next       = wp_reg + {{(AW-2){1'b0}}, push_cnt};
        rp_next       = rp_reg + {{(AW-1){1'b0}}, pop_eff};
        count_next    = n_sum[AW:0];
        overflow_next = overflow_reg;
        if (Clear) begin
            wp_next       = '0;
            rp_next       = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else if (n_sum > DEPTH_W) begin
            excess        = n_sum - DEPTH_W;
            rp_next       = rp_reg + {{(AW-1){1'b0}}, pop_eff} + excess[AW-1:0];
            count_next    = DEPTH_C;
            overflow_next = 1'b1;
        end
    end

    // Pointer, occupancy and sticky-overflow registers. Reset is asynchronous.
    always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
        if (RST_CPU) begin
            wp_reg       <= '0;
            rp_reg       <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wp_reg       <= wp_next;
            rp_reg       <= rp_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Array writes for the GPR event at wp and the store event at wp or wp+1.
    always_ff @(posedge CLK_CPU) begin
        if (!RST_CPU && capture && RegWrite) begin
            kind_mem[wp_reg] <= KIND_GPR;
            addr_mem[wp_reg] <= {11'd0, WriteRegister};
            data_mem[wp_reg] <= WriteData;
`ifdef TRACE_PC_EN
            pc_mem[wp_reg]   <= WbPC;
`endif
        end
        if (!RST_CPU && capture && DMemW) begin
            kind_mem[store_idx] <= KIND_STORE;
            addr_mem[store_idx] <= DataAddr[15:0];
            data_mem[store_idx] <= DataIn;
`ifdef TRACE_PC_EN
            pc_mem[store_idx]   <= MemPC;
`endif
        end
    end

    // Read side: show the head entry, and force all fields to 0 while empty.
    always_comb begin
        Valid     = (count_reg != '0);
        Count     = count_reg;
        Overflow  = overflow_reg;
        EntryKind = Valid ? kind_mem[rp_reg] : 2'd0;
        EntryAddr = Valid ? addr_mem[rp_reg] : 16'd0;
        EntryData = Valid ? data_mem[rp_reg] : 32'd0;
`ifdef TRACE_PC_EN
        EntryPC   = Valid ? pc_mem[rp_reg] : 32'd0;
        unused_ok = ^{DataAddr[31:16], excess[AW+1:AW]};
`else
        EntryPC   = 32'd0;
        unused_ok = ^{DataAddr[31:16], excess[AW+1:AW], WbPC, MemPC};
`endif
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed testbench for wb_trace_fifo with DEPTH=16.
// It checks expected values with immediate assertions at each step.
module tb_wb_trace_fifo;

    logic        CLK_CPU = 1'b0;
    logic        RST_CPU;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] WbPC;
    logic        DMemW;
    logic [31:0] DataAddr;
    logic [31:0] DataIn;
    logic [31:0] MemPC;
    logic        Freeze;
    logic        Clear;
    logic        Pop;
    logic        Valid;
    logic [1:0]  EntryKind;
    logic [15:0] EntryAddr;
    logic [31:0] EntryData;
    logic [31:0] EntryPC;
    logic [4:0]  Count;
    logic        Overflow;

    int checks = 0;
    int errors = 0;

    wb_trace_fifo #(.DEPTH(16), .AW(4)) dut (
        .CLK_CPU(CLK_CPU), .RST_CPU(RST_CPU),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .WbPC(WbPC),
        .DMemW(DMemW), .DataAddr(DataAddr), .DataIn(DataIn), .MemPC(MemPC),
        .Freeze(Freeze), .Clear(Clear), .Pop(Pop),
        .Valid(Valid), .EntryKind(EntryKind), .EntryAddr(EntryAddr),
        .EntryData(EntryData), .EntryPC(EntryPC),
        .Count(Count), .Overflow(Overflow)
    );

    always #5 CLK_CPU = ~CLK_CPU;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to just after the next rising edge, away from the edge itself.
    task automatic tick();
        @(posedge CLK_CPU);
        #1;
    endtask

    task automatic push_gpr(input logic [4:0] r, input logic [31:0] d, input logic [31:0] pc);
        RegWrite = 1'b1; WriteRegister = r; WriteData = d; WbPC = pc;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic pop_one();
        Pop = 1'b1;
        tick();
        Pop = 1'b0;
    endtask

    logic [31:0] pc_exp;

    initial begin
        RST_CPU = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0; WbPC = '0;
        DMemW = 1'b0; DataAddr = '0; DataIn = '0; MemPC = '0;
        Freeze = 1'b0; Clear = 1'b0; Pop = 1'b0;
        tick(); tick();
        check("rst_valid", {31'd0, Valid}, 32'd0);
        check("rst_count", {27'd0, Count}, 32'd0);
        check("rst_ovf", {31'd0, Overflow}, 32'd0);
        check("rst_kind", {30'd0, EntryKind}, 32'd0);
        check("rst_data", EntryData, 32'd0);
        check("rst_pc", EntryPC, 32'd0);
        RST_CPU = 1'b0;

        // Single GPR write: it should be visible right after the capture edge.
        push_gpr(5'd8, 32'h0000_0005, 32'h0000_3008);
`ifdef TRACE_PC_EN
        pc_exp = 32'h0000_3008;
`else
        pc_exp = 32'h0;
`endif
        $display("txn gpr r8=5 count=%0d kind=%0d", Count, EntryKind);
        check("w1_valid", {31'd0, Valid}, 32'd1);
        check("w1_kind", {30'd0, EntryKind}, 32'd1);
        check("w1_addr", {16'd0, EntryAddr}, 32'h8);
        check("w1_data", EntryData, 32'd5);
        check("w1_count", {27'd0, Count}, 32'd1);
        check("w1_pc", EntryPC, pc_exp);
        pop_one();
        check("w1_pop_valid", {31'd0, Valid}, 32'd0);
        check("w1_pop_kind", {30'd0, EntryKind}, 32'd0);

        // GPR write and store in the same cycle: the GPR entry comes first.
        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h11; WbPC = 32'h100;
        DMemW = 1'b1; DataAddr = 32'hABCD_0004; DataIn = 32'h22; MemPC = 32'h104;
        tick();
        RegWrite = 1'b0; DMemW = 1'b0;
        $display("txn dual r9=11 st[4]=22 count=%0d", Count);
        check("dual_count", {27'd0, Count}, 32'd2);
        check("dual_kind0", {30'd0, EntryKind}, 32'd1);
        check("dual_addr0", {16'd0, EntryAddr}, 32'h9);
        check("dual_data0", EntryData, 32'h11);
        pop_one();
`ifdef TRACE_PC_EN
        pc_exp = 32'h104;
`else
        pc_exp = 32'h0;
`endif
        check("dual_kind1", {30'd0, EntryKind}, 32'd2);
        check("dual_addr1", {16'd0, EntryAddr}, 32'h4);
        check("dual_data1", EntryData, 32'h22);
        check("dual_pc1", EntryPC, pc_exp);
        check("dual_count1", {27'd0, Count}, 32'd1);
        pop_one();
        check("dual_empty", {31'd0, Valid}, 32'd0);

        // Pop on an empty buffer has no effect.
        pop_one();
        $display("txn pop_empty count=%0d", Count);
        check("pop_empty_count", {27'd0, Count}, 32'd0);
        check("pop_empty_ovf", {31'd0, Overflow}, 32'd0);

        // Fill to exactly DEPTH entries: the buffer is full but has not overflowed.
        for (int i = 1; i <= 16; i++) push_gpr(5'(i), 32'(i), 32'h0);
        check("full_count", {27'd0, Count}, 32'd16);
        check("full_ovf", {31'd0, Overflow}, 32'd0);
        check("full_head", EntryData, 32'd1);
        for (int i = 17; i <= 19; i++) push_gpr(5'(i), 32'(i), 32'h0);
        $display("txn 19 pushes count=%0d ovf=%0d head=%0d", Count, Overflow, EntryData);
        check("ovf_count", {27'd0, Count}, 32'd16);
        check("ovf_flag", {31'd0, Overflow}, 32'd1);
        check("ovf_head", EntryData, 32'd4);
        check("ovf_head_addr", {16'd0, EntryAddr}, 32'd4);

        // Full buffer, pop plus one push: Count stays at DEPTH and the head advances by one.
        Pop = 1'b1;
        push_gpr(5'd20, 32'd20, 32'h0);
        Pop = 1'b0;
        $display("txn pop+push full count=%0d head=%0d", Count, EntryData);
        check("pp_count", {27'd0, Count}, 32'd16);
        check("pp_ovf", {31'd0, Overflow}, 32'd1);
        check("pp_head", EntryData, 32'd5);

        // Full buffer, pop plus two pushes: one entry is lost and the head moves by two.
        Pop = 1'b1; DMemW = 1'b1; DataAddr = 32'h40; DataIn = 32'd22;
        push_gpr(5'd21, 32'd21, 32'h0);
        Pop = 1'b0; DMemW = 1'b0;
        $display("txn pop+dual full count=%0d head=%0d", Count, EntryData);
        check("pp2_count", {27'd0, Count}, 32'd16);
        check("pp2_head", EntryData, 32'd7);

        // Clear takes priority over a pop and a capture in the same cycle.
        Clear = 1'b1; Pop = 1'b1;
        push_gpr(5'd1, 32'hDEAD, 32'h0);
        Clear = 1'b0; Pop = 1'b0;
        $display("txn clear count=%0d ovf=%0d", Count, Overflow);
        check("clr_count", {27'd0, Count}, 32'd0);
        check("clr_ovf", {31'd0, Overflow}, 32'd0);
        check("clr_valid", {31'd0, Valid}, 32'd0);

        // Freeze drops captures, but pops still act.
        push_gpr(5'd3, 32'h77, 32'h0);
        Freeze = 1'b1;
        for (int i = 0; i < 5; i++) push_gpr(5'd4, 32'(100 + i), 32'h0);
        $display("txn freeze 5 writes count=%0d", Count);
        check("frz_count", {27'd0, Count}, 32'd1);
        check("frz_head", EntryData, 32'h77);
        pop_one();
        check("frz_pop", {27'd0, Count}, 32'd0);
        Freeze = 1'b0;

        // Reset asserted mid-stream clears outputs immediately, without a clock edge.
        for (int i = 0; i < 7; i++) push_gpr(5'd2, 32'(200 + i), 32'h0);
        check("pre_rst_count", {27'd0, Count}, 32'd7);
        #2;
        RST_CPU = 1'b1;
        #1;
        $display("txn async reset count=%0d valid=%0d", Count, Valid);
        check("arst_count", {27'd0, Count}, 32'd0);
        check("arst_valid", {31'd0, Valid}, 32'd0);
        check("arst_data", EntryData, 32'd0);
        tick();
        RST_CPU = 1'b0;

        // Capture resumes after reset, and EntryPC shows the recorded WbPC when built in.
        push_gpr(5'd10, 32'hCAFE, 32'h0000_3008);
`ifdef TRACE_PC_EN
        pc_exp = 32'h0000_3008;
`else
        pc_exp = 32'h0;
`endif
        $display("txn post-reset gpr r10 pc=%0h", EntryPC);
        check("post_count", {27'd0, Count}, 32'd1);
        check("post_data", EntryData, 32'hCAFE);
        check("post_pc", EntryPC, pc_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
